// File: rtl/cep_decoder_stream_pkg.sv
// Shared CEP packet layout, length caps, state encodings and small helpers
// used by the CEP receive-side decoder and its field extractor.
package cep_decoder_stream_pkg;

  localparam int CEP_WORD_WIDTH = 64;
  localparam int CEP_NUM_WORDS  = 8;
  localparam int CEP_DATA_WIDTH = CEP_WORD_WIDTH * CEP_NUM_WORDS;
  localparam int CEP_IDX_WIDTH  = $clog2(CEP_NUM_WORDS);

  // Field positions are absolute bit offsets in the packet (word 0 at the LSBs)
  localparam int CEP_MSG_TYPE_LSB     = 0;
  localparam int CEP_MSG_TYPE_W       = 8;
  localparam int CEP_LENGTH_LSB       = 8;
  localparam int CEP_LENGTH_W         = 8;
  localparam int CEP_MSHRID_LSB       = 16;
  localparam int CEP_MSHRID_W         = 8;
  localparam int CEP_MESI_LSB         = 24;
  localparam int CEP_MESI_W           = 2;
  localparam int CEP_SUBLINE_ID_LSB   = 26;
  localparam int CEP_SUBLINE_ID_W     = 2;
  localparam int CEP_LAST_SUBLINE_POS = 28;
  localparam int CEP_IS_REQUEST_POS   = 29;
  localparam int CEP_ADDR_LSB         = 64;
  localparam int CEP_ADDR_W           = 48;
  localparam int CEP_DATA_SIZE_LSB    = 112;
  localparam int CEP_DATA_SIZE_W      = 3;
  localparam int CEP_CACHE_TYPE_POS   = 115;
  localparam int CEP_SRC_CHIPID_LSB   = 116;
  localparam int CEP_SRC_CHIPID_W     = 12;

  localparam logic [CEP_IDX_WIDTH-1:0] CEP_REQ_MAX_WORDS  = 3'd5;
  localparam logic [CEP_IDX_WIDTH-1:0] CEP_RESP_MAX_WORDS = 3'd7;
  localparam logic [CEP_IDX_WIDTH-1:0] CEP_REQ_DATA_BASE  = 3'd3;
  localparam logic [CEP_IDX_WIDTH-1:0] CEP_RESP_DATA_BASE = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } cep_state_e;

  typedef struct packed {
    logic                        is_request;
    logic                        last_subline;
    logic [CEP_SUBLINE_ID_W-1:0] subline_id;
    logic [CEP_MESI_W-1:0]       mesi;
    logic [CEP_MSHRID_W-1:0]     mshrid;
    logic [CEP_MSG_TYPE_W-1:0]   msg_type;
    logic [CEP_LENGTH_W-1:0]     length;
    logic [CEP_DATA_SIZE_W-1:0]  data_size;
    logic                        cache_type;
    logic [CEP_ADDR_W-1:0]       addr;
    logic [CEP_SRC_CHIPID_W-1:0] src_chipid;
  } cep_fields_t;

  function automatic logic [CEP_WORD_WIDTH-1:0] cep_word(
    input logic [CEP_DATA_WIDTH-1:0] pkt,
    input logic [CEP_IDX_WIDTH-1:0]  idx
  );
    return pkt[int'(idx)*CEP_WORD_WIDTH +: CEP_WORD_WIDTH];
  endfunction

  function automatic logic [CEP_LENGTH_W-1:0] cep_len_cap(input logic is_req);
    return is_req ? {5'd0, CEP_REQ_MAX_WORDS} : {5'd0, CEP_RESP_MAX_WORDS};
  endfunction

  function automatic logic cep_len_over(
    input logic                    is_req,
    input logic [CEP_LENGTH_W-1:0] length
  );
    return (length > cep_len_cap(is_req));
  endfunction

  function automatic logic [CEP_IDX_WIDTH-1:0] cep_eff_len(
    input logic                    is_req,
    input logic [CEP_LENGTH_W-1:0] length
  );
    logic [CEP_LENGTH_W-1:0] cap;
    cap = cep_len_cap(is_req);
    return cep_len_over(is_req, length) ? cap[CEP_IDX_WIDTH-1:0] : length[CEP_IDX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/cep_decoder_stream_field_decoder.sv
// Purely combinational extraction of the CEP header fields from a packet;
// request-only fields read as zero for responses.
module cep_field_decoder
  import cep_decoder_stream_pkg::*;
(
  input  logic [CEP_DATA_WIDTH-1:0] pkt,
  output cep_fields_t               fields
);

  // Words 2..7 and the top of word 0 carry no header information here
  logic unused_bits_s;
  assign unused_bits_s = ^{pkt[CEP_DATA_WIDTH-1:128], pkt[63:30]};

  // Common fields always decode; request-only fields only for requests
  always_comb begin
    fields              = '0;
    fields.is_request   = pkt[CEP_IS_REQUEST_POS];
    fields.last_subline = pkt[CEP_LAST_SUBLINE_POS];
    fields.subline_id   = pkt[CEP_SUBLINE_ID_LSB +: CEP_SUBLINE_ID_W];
    fields.mesi         = pkt[CEP_MESI_LSB +: CEP_MESI_W];
    fields.mshrid       = pkt[CEP_MSHRID_LSB +: CEP_MSHRID_W];
    fields.msg_type     = pkt[CEP_MSG_TYPE_LSB +: CEP_MSG_TYPE_W];
    fields.length       = pkt[CEP_LENGTH_LSB +: CEP_LENGTH_W];
    if (pkt[CEP_IS_REQUEST_POS]) begin
      fields.data_size  = pkt[CEP_DATA_SIZE_LSB +: CEP_DATA_SIZE_W];
      fields.cache_type = pkt[CEP_CACHE_TYPE_POS];
      fields.addr       = pkt[CEP_ADDR_LSB +: CEP_ADDR_W];
      fields.src_chipid = pkt[CEP_SRC_CHIPID_LSB +: CEP_SRC_CHIPID_W];
    end else begin
      fields.data_size  = {CEP_DATA_SIZE_W{1'b0}};
      fields.cache_type = 1'b0;
      fields.addr       = {CEP_ADDR_W{1'b0}};
      fields.src_chipid = {CEP_SRC_CHIPID_W{1'b0}};
    end
  end

endmodule

// File: rtl/cep_decoder_stream.sv
// CEP receive-side decoder: accepts one full packet per handshake and streams
// it out as a header beat followed by the (clamped) payload words.
module cep_decoder_stream
  import cep_decoder_stream_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cep_val,
  output logic                        cep_rdy,
  input  logic [CEP_DATA_WIDTH-1:0]   cep_pkg,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic                        out_hdr,
  output logic                        out_last,
  output logic [CEP_WORD_WIDTH-1:0]   out_data,
  output logic                        out_is_request,
  output logic                        out_last_subline,
  output logic [CEP_SUBLINE_ID_W-1:0] out_subline_id,
  output logic [CEP_MESI_W-1:0]       out_mesi,
  output logic [CEP_MSHRID_W-1:0]     out_mshrid,
  output logic [CEP_MSG_TYPE_W-1:0]   out_msg_type,
  output logic [CEP_LENGTH_W-1:0]     out_length,
  output logic [CEP_DATA_SIZE_W-1:0]  out_data_size,
  output logic                        out_cache_type,
  output logic [CEP_ADDR_W-1:0]       out_addr,
  output logic [CEP_SRC_CHIPID_W-1:0] out_src_chipid,
  output logic                        out_len_err
);

  cep_state_e                state_r;
  logic [CEP_DATA_WIDTH-1:0] pkt_r;
  logic [CEP_IDX_WIDTH-1:0]  idx_r;
  logic [CEP_IDX_WIDTH-1:0]  eff_len_r;
  cep_fields_t               fld_s;
  logic                      end_s;
  logic                      load_s;
  logic [CEP_IDX_WIDTH-1:0]  base_s;
  logic [CEP_IDX_WIDTH-1:0]  idx_nxt_s;
  logic [CEP_IDX_WIDTH-1:0]  word_nxt_s;
  logic                      in_req_s;
  logic [CEP_LENGTH_W-1:0]   in_len_s;
  logic [CEP_IDX_WIDTH-1:0]  in_eff_s;
  logic                      in_over_s;

  cep_field_decoder u_field_decoder (
    .pkt    (pkt_r),
    .fields (fld_s)
  );

  // Handshake glue; cep_rdy only looks at out_rdy during the last beat
  always_comb begin
    end_s      = out_val && out_rdy && out_last;
    cep_rdy    = (state_r == ST_IDLE) || end_s;
    load_s     = cep_val && cep_rdy;
    base_s     = fld_s.is_request ? CEP_REQ_DATA_BASE : CEP_RESP_DATA_BASE;
    idx_nxt_s  = idx_r + 3'd1;
    word_nxt_s = base_s + idx_nxt_s;
    in_req_s   = cep_pkg[CEP_IS_REQUEST_POS];
    in_len_s   = cep_pkg[CEP_LENGTH_LSB +: CEP_LENGTH_W];
    in_eff_s   = cep_eff_len(in_req_s, in_len_s);
    in_over_s  = cep_len_over(in_req_s, in_len_s);
  end

  // Packet FSM with all beat outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pkt_r       <= {CEP_DATA_WIDTH{1'b0}};
      idx_r       <= 3'd0;
      eff_len_r   <= 3'd0;
      out_val     <= 1'b0;
      out_hdr     <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= {CEP_WORD_WIDTH{1'b0}};
      out_len_err <= 1'b0;
    end else if (load_s) begin
      // Also taken on the last-beat handshake, giving bubble-free packets
      state_r     <= ST_HDR;
      pkt_r       <= cep_pkg;
      idx_r       <= 3'd0;
      eff_len_r   <= in_eff_s;
      out_val     <= 1'b1;
      out_hdr     <= 1'b1;
      out_last    <= (in_eff_s == 3'd0);
      out_data    <= {CEP_WORD_WIDTH{1'b0}};
      out_len_err <= in_over_s;
    end else if (end_s) begin
      state_r     <= ST_IDLE;
      idx_r       <= 3'd0;
      out_val     <= 1'b0;
      out_hdr     <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= {CEP_WORD_WIDTH{1'b0}};
      out_len_err <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_HDR: begin
          if (out_rdy) begin
            state_r  <= ST_DATA;
            idx_r    <= 3'd0;
            out_hdr  <= 1'b0;
            out_data <= cep_word(pkt_r, base_s);
            out_last <= (eff_len_r == 3'd1);
          end
        end
        ST_DATA: begin
          if (out_rdy) begin
            idx_r    <= idx_nxt_s;
            out_data <= cep_word(pkt_r, word_nxt_s);
            out_last <= (idx_nxt_s == (eff_len_r - 3'd1));
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          idx_r       <= 3'd0;
          out_val     <= 1'b0;
          out_hdr     <= 1'b0;
          out_last    <= 1'b0;
          out_data    <= {CEP_WORD_WIDTH{1'b0}};
          out_len_err <= 1'b0;
        end
      endcase
    end
  end

  assign out_is_request   = fld_s.is_request;
  assign out_last_subline = fld_s.last_subline;
  assign out_subline_id   = fld_s.subline_id;
  assign out_mesi         = fld_s.mesi;
  assign out_mshrid       = fld_s.mshrid;
  assign out_msg_type     = fld_s.msg_type;
  assign out_length       = fld_s.length;
  assign out_data_size    = fld_s.data_size;
  assign out_cache_type   = fld_s.cache_type;
  assign out_addr         = fld_s.addr;
  assign out_src_chipid   = fld_s.src_chipid;

endmodule

// File: tb/tb_cep_decoder_stream.sv
// Directed self-checking bench for cep_decoder_stream.
module tb_cep_decoder_stream;

  logic         clk, rst, cep_val, cep_rdy, out_val, out_rdy, out_hdr, out_last;
  logic [511:0] cep_pkg;
  logic [63:0]  out_data;
  logic         out_is_request, out_last_subline, out_cache_type, out_len_err;
  logic [1:0]   out_subline_id, out_mesi;
  logic [7:0]   out_mshrid, out_msg_type, out_length;
  logic [2:0]   out_data_size;
  logic [47:0]  out_addr;
  logic [11:0]  out_src_chipid;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] bd [0:15];
  logic        bh [0:15];
  logic        bl [0:15];
  logic        be [0:15];
  int          nb, ncyc;

  cep_decoder_stream dut (
    .clk(clk), .rst(rst), .cep_val(cep_val), .cep_rdy(cep_rdy), .cep_pkg(cep_pkg),
    .out_val(out_val), .out_rdy(out_rdy), .out_hdr(out_hdr), .out_last(out_last),
    .out_data(out_data), .out_is_request(out_is_request), .out_last_subline(out_last_subline),
    .out_subline_id(out_subline_id), .out_mesi(out_mesi), .out_mshrid(out_mshrid),
    .out_msg_type(out_msg_type), .out_length(out_length), .out_data_size(out_data_size),
    .out_cache_type(out_cache_type), .out_addr(out_addr), .out_src_chipid(out_src_chipid),
    .out_len_err(out_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word 0: [29] is_request, [28] last_subline, [27:26] subline, [25:24] mesi,
  // [23:16] mshrid, [15:8] length, [7:0] msg_type
  function automatic logic [63:0] mk_w0(input logic req, input logic [7:0] len,
                                        input logic [7:0] msg, input logic [7:0] mshr);
    logic [63:0] w;
    w = 64'd0;
    w[29] = req; w[15:8] = len; w[7:0] = msg; w[23:16] = mshr;
    return w;
  endfunction

  task automatic send(input logic [511:0] p);
    int waited;
    waited = 0;
    cep_pkg = p; cep_val = 1'b1;
    while (!cep_rdy && waited < 20) begin @(posedge clk); #1; waited++; end
    n_vec++;
    if (cep_rdy !== 1'b1) begin
      n_err++; $display("FAIL send_accept: cep_rdy=%0b after %0d cycles, expected 1", cep_rdy, waited);
      cep_val = 1'b0;
    end else begin
      @(posedge clk); #1; cep_val = 1'b0;
    end
  endtask

  task automatic collect(input int max_cyc);
    bit done;
    nb = 0; ncyc = 0; done = 0;
    while (!done && ncyc < max_cyc) begin
      if (out_val && out_rdy) begin
        if (nb < 16) begin bd[nb] = out_data; bh[nb] = out_hdr; bl[nb] = out_last; be[nb] = out_len_err; end
        nb++;
        if (out_last) done = 1;
      end
      @(posedge clk); #1; ncyc++;
    end
    n_vec++;
    if (!done) begin n_err++; $display("FAIL collect_timeout: no last beat in %0d cycles, expected one", max_cyc); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cep_val = 1'b0; out_rdy = 1'b1; cep_pkg = '0;
    #12;
    n_vec++; if (cep_rdy !== 1'b1) begin n_err++; $display("FAIL reset_cep_rdy: got %0b expected 1", cep_rdy); end
    n_vec++; if (out_val !== 1'b0) begin n_err++; $display("FAIL reset_out_val: got %0b expected 0", out_val); end
    n_vec++; if ({out_hdr, out_last, out_len_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {out_hdr, out_last, out_len_err}); end
    n_vec++; if (out_data !== 64'd0) begin n_err++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_vec++; if ({out_is_request, out_length, out_addr, out_src_chipid, out_msg_type} !== 77'd0) begin n_err++; $display("FAIL reset_fields: got nonzero fields, expected 0"); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_vec++; if ({cep_rdy, out_val} !== 2'b10) begin n_err++; $display("FAIL idle_after_reset: got rdy/val %b expected 10", {cep_rdy, out_val}); end
  endtask

  task automatic test_response7();
    logic [511:0] p;
    p = '0; p[63:0] = mk_w0(1'b0, 8'd7, 8'h33, 8'h44);
    for (int i = 1; i < 8; i++) p[i*64 +: 64] = 64'(i) * 64'h11;
    out_rdy = 1'b1;
    send(p);
    n_vec++; if ({out_val, out_hdr} !== 2'b11) begin n_err++; $display("FAIL resp7_hdr_latency: got val/hdr %b expected 11", {out_val, out_hdr}); end
    n_vec++; if ({out_is_request, out_length, out_msg_type, out_mshrid} !== {1'b0, 8'd7, 8'h33, 8'h44}) begin n_err++; $display("FAIL resp7_fields: got req=%0b len=%0d msg=%h mshr=%h expected 0/7/33/44", out_is_request, out_length, out_msg_type, out_mshrid); end
    n_vec++; if ({out_addr, out_src_chipid, out_data_size, out_cache_type} !== 64'd0) begin n_err++; $display("FAIL resp7_req_fields_zero: got addr=%h chip=%h expected 0", out_addr, out_src_chipid); end
    collect(30);
    n_vec++; if (nb !== 8 || ncyc !== 8) begin n_err++; $display("FAIL resp7_count: got %0d beats in %0d cycles expected 8 in 8", nb, ncyc); end
    for (int b = 0; b < 8 && b < nb; b++) begin
      n_vec++;
      if (bd[b] !== 64'(b) * 64'h11 || bh[b] !== (b == 0) || bl[b] !== (b == 7) || be[b] !== 1'b0) begin
        n_err++; $display("FAIL resp7_beat%0d: got data=%h hdr=%0b last=%0b err=%0b expected data=%h hdr=%0b last=%0b err=0",
                          b, bd[b], bh[b], bl[b], be[b], 64'(b) * 64'h11, (b == 0), (b == 7));
      end
    end
  endtask

  task automatic test_request2();
    logic [511:0] p;
    logic [63:0]  w0;
    w0 = mk_w0(1'b1, 8'd2, 8'h5A, 8'h21);
    w0[25:24] = 2'd2; w0[27:26] = 2'd1; w0[28] = 1'b1;
    p = '0; p[63:0] = w0;
    p[127:64] = {12'd3, 1'b1, 3'd6, 48'h0000_0040_1000};
    p[3*64 +: 64] = 64'hA; p[4*64 +: 64] = 64'hB;
    out_rdy = 1'b1;
    send(p);
    n_vec++; if ({out_is_request, out_addr, out_src_chipid} !== {1'b1, 48'h0000_0040_1000, 12'd3}) begin n_err++; $display("FAIL req2_addr_chip: got req=%0b addr=%h chip=%0d expected 1/000000401000/3", out_is_request, out_addr, out_src_chipid); end
    n_vec++; if ({out_data_size, out_cache_type, out_mesi, out_subline_id, out_last_subline} !== {3'd6, 1'b1, 2'd2, 2'd1, 1'b1}) begin n_err++; $display("FAIL req2_misc_fields: got size=%0d ct=%0b mesi=%0d sub=%0d ls=%0b expected 6/1/2/1/1", out_data_size, out_cache_type, out_mesi, out_subline_id, out_last_subline); end
    n_vec++; if ({out_msg_type, out_mshrid, out_length, out_len_err} !== {8'h5A, 8'h21, 8'd2, 1'b0}) begin n_err++; $display("FAIL req2_common: got msg=%h mshr=%h len=%0d err=%0b expected 5a/21/2/0", out_msg_type, out_mshrid, out_length, out_len_err); end
    collect(20);
    n_vec++; if (nb !== 3) begin n_err++; $display("FAIL req2_count: got %0d beats expected 3", nb); end
    n_vec++; if (nb == 3 && ({bd[0], bd[1], bd[2]} !== {64'h0, 64'hA, 64'hB} || {bl[0], bl[1], bl[2]} !== 3'b001 || {bh[0], bh[1], bh[2]} !== 3'b100)) begin
      n_err++; $display("FAIL req2_beats: got %h %h %h last=%b expected 0 a b last=001", bd[0], bd[1], bd[2], {bl[0], bl[1], bl[2]});
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] a, bp;
    a = '0; a[63:0] = mk_w0(1'b0, 8'd0, 8'h01, 8'h00);
    bp = '0; bp[63:0] = mk_w0(1'b0, 8'd1, 8'h02, 8'h00); bp[127:64] = 64'hBEEF;
    out_rdy = 1'b1;
    send(a);
    n_vec++; if ({out_val, out_hdr, out_last, cep_rdy} !== 4'b1111 || out_data !== 64'd0) begin n_err++; $display("FAIL len0_single_beat: got val/hdr/last/rdy=%b data=%h expected 1111 data 0", {out_val, out_hdr, out_last, cep_rdy}, out_data); end
    cep_pkg = bp; cep_val = 1'b1;
    @(posedge clk); #1; cep_val = 1'b0;
    n_vec++; if ({out_val, out_hdr, out_msg_type, out_length} !== {1'b1, 1'b1, 8'h02, 8'd1}) begin n_err++; $display("FAIL b2b_no_bubble: got val=%0b hdr=%0b msg=%h len=%0d expected 1/1/02/1", out_val, out_hdr, out_msg_type, out_length); end
    collect(20);
    n_vec++; if (nb !== 2 || ncyc !== 2 || bd[1] !== 64'hBEEF || bl[0] !== 1'b0 || bl[1] !== 1'b1) begin n_err++; $display("FAIL b2b_second_pkt: got %0d beats/%0d cycles data1=%h expected 2/2 beef", nb, ncyc, bd[1]); end
  endtask

  task automatic test_len_clamp();
    logic [511:0] p;
    p = '0; p[63:0] = mk_w0(1'b1, 8'd6, 8'h07, 8'h08);
    for (int i = 3; i < 8; i++) p[i*64 +: 64] = 64'(i) * 64'h10;
    out_rdy = 1'b1;
    send(p);
    n_vec++; if ({out_len_err, out_length} !== {1'b1, 8'd6}) begin n_err++; $display("FAIL clamp_hdr: got err=%0b len=%0d expected 1/6", out_len_err, out_length); end
    collect(20);
    n_vec++; if (nb !== 6) begin n_err++; $display("FAIL clamp_count: got %0d beats expected 6", nb); end
    for (int b = 0; b < 6 && b < nb; b++) begin
      n_vec++;
      if (bd[b] !== ((b == 0) ? 64'd0 : 64'(b + 2) * 64'h10) || bl[b] !== (b == 5) || be[b] !== 1'b1) begin
        n_err++; $display("FAIL clamp_beat%0d: got data=%h last=%0b err=%0b expected data=%h last=%0b err=1",
                          b, bd[b], bl[b], be[b], (b == 0) ? 64'd0 : 64'(b + 2) * 64'h10, (b == 5));
      end
    end
  endtask

  task automatic test_stall();
    logic [511:0] p;
    logic [63:0]  exp_d [0:4];
    logic         rdy_seq [0:4];
    p = '0; p[63:0] = mk_w0(1'b0, 8'd3, 8'h09, 8'h0A);
    for (int i = 1; i < 4; i++) p[i*64 +: 64] = 64'(i) * 64'h101;
    exp_d[0] = 64'h101; exp_d[1] = 64'h202; exp_d[2] = 64'h202; exp_d[3] = 64'h202; exp_d[4] = 64'h303;
    rdy_seq[0] = 1'b1; rdy_seq[1] = 1'b0; rdy_seq[2] = 1'b0; rdy_seq[3] = 1'b1; rdy_seq[4] = 1'b1;
    out_rdy = 1'b1;
    send(p);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      out_rdy = rdy_seq[k];
      #1;
      n_vec++;
      if (out_val !== 1'b1 || out_data !== exp_d[k] || out_last !== (k == 4) || cep_rdy !== (k == 4) || out_hdr !== 1'b0) begin
        n_err++; $display("FAIL stall_step%0d: got val=%0b data=%h last=%0b cep_rdy=%0b expected 1 %h %0b %0b",
                          k, out_val, out_data, out_last, cep_rdy, exp_d[k], (k == 4), (k == 4));
      end
      @(posedge clk); #1;
    end
    n_vec++; if (out_val !== 1'b0) begin n_err++; $display("FAIL stall_end: got out_val=%0b expected 0", out_val); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] p, q;
    p = '0; p[63:0] = mk_w0(1'b0, 8'd7, 8'h0B, 8'h0C);
    for (int i = 1; i < 8; i++) p[i*64 +: 64] = 64'h1000 + 64'(i);
    out_rdy = 1'b1;
    send(p);
    repeat (3) begin @(posedge clk); #1; end
    n_vec++; if (out_data !== 64'h1003) begin n_err++; $display("FAIL rst_mid_position: got %h expected 1003", out_data); end
    rst = 1'b1;
    #2;
    n_vec++; if ({out_val, out_hdr, out_last, cep_rdy} !== 4'b0001 || out_data !== 64'd0 || out_length !== 8'd0) begin n_err++; $display("FAIL rst_mid_async: got val/hdr/last/rdy=%b data=%h len=%0d expected 0001 0 0", {out_val, out_hdr, out_last, cep_rdy}, out_data, out_length); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++; if ({out_val, out_last} !== 2'b00) begin n_err++; $display("FAIL rst_mid_discard: got val/last=%b expected 00", {out_val, out_last}); end
    q = '0; q[63:0] = mk_w0(1'b0, 8'd2, 8'h0D, 8'h0E);
    q[127:64] = 64'hC1; q[191:128] = 64'hC2;
    send(q);
    n_vec++; if ({out_hdr, out_length} !== {1'b1, 8'd2}) begin n_err++; $display("FAIL rst_mid_next_hdr: got hdr=%0b len=%0d expected 1/2", out_hdr, out_length); end
    collect(20);
    n_vec++; if (nb !== 3 || bd[1] !== 64'hC1 || bd[2] !== 64'hC2 || {bl[0], bl[1], bl[2]} !== 3'b001) begin n_err++; $display("FAIL rst_mid_next_pkt: got %0d beats %h %h expected 3 beats c1 c2", nb, bd[1], bd[2]); end
  endtask

  initial begin
    test_reset();
    test_response7();
    test_request2();
    test_back_to_back();
    test_len_clamp();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
